// File: rtl/comparator_pkg.sv
// Shared types and constants for the slice-serial comparator controller.
package comparator_pkg;

  localparam int SLICE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  // One-hot result codes ordered {LT, EQ, GT}; RES_NONE means "no decision yet".
  localparam logic [2:0] RES_NONE = 3'b000;
  localparam logic [2:0] RES_LT   = 3'b100;
  localparam logic [2:0] RES_EQ   = 3'b010;
  localparam logic [2:0] RES_GT   = 3'b001;

endpackage

// File: rtl/comparator_seq_ctrl_cmp_slice4.sv
// Combinational unsigned compare of one 4-bit slice pair.
module cmp_slice4
  import comparator_pkg::*;
(
  input  logic [SLICE_W-1:0] a_i,
  input  logic [SLICE_W-1:0] b_i,
  output logic               lt_o,
  output logic               eq_o,
  output logic               gt_o
);

  assign lt_o = (a_i <  b_i);
  assign eq_o = (a_i == b_i);
  assign gt_o = (a_i >  b_i);

endmodule

// File: rtl/comparator_seq_ctrl.sv
// Time-shares one 4-bit compare slice across WIDTH-bit operands, MSB slice first.
// Optional feature: define COMPARATOR_EARLY_EXIT_EN to finish on the first unequal slice.
module comparator_seq_ctrl
  import comparator_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                                CLK,
  input  logic                                RST,
  input  logic                                IN_VALID,
  output logic                                IN_READY,
  input  logic [WIDTH-1:0]                    A,
  input  logic [WIDTH-1:0]                    B,
  output logic                                OUT_VALID,
  input  logic                                OUT_READY,
  output logic                                LT_OUT,
  output logic                                EQ_OUT,
  output logic                                GT_OUT,
  output logic [$clog2(WIDTH/SLICE_W+1)-1:0]  SLICES
);

  localparam int NSLICES  = WIDTH / SLICE_W;
  localparam int SLICES_W = $clog2(NSLICES + 1);
  localparam int IDX_W    = (NSLICES > 1) ? $clog2(NSLICES) : 1;
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(NSLICES - 1);

  if ((WIDTH % SLICE_W) != 0 || WIDTH < SLICE_W) begin : gWidthCheck
    $error("comparator_seq_ctrl: WIDTH must be a multiple of 4 and at least 4");
  end

  state_t                           state_q, state_d;
  logic [NSLICES-1:0][SLICE_W-1:0]  opA_q, opA_d;
  logic [NSLICES-1:0][SLICE_W-1:0]  opB_q, opB_d;
  logic [IDX_W-1:0]                 idx_q, idx_d;
  logic [SLICES_W-1:0]              slices_q, slices_d;
  logic [2:0]                       res_q, res_d;

  logic [SLICE_W-1:0] sliceA;
  logic [SLICE_W-1:0] sliceB;
  logic               sliceLt;
  logic               sliceEq;
  logic               sliceGt;
  logic               runDone;

  assign sliceA = opA_q[idx_q];
  assign sliceB = opB_q[idx_q];

  cmp_slice4 uSlice (
    .a_i  (sliceA),
    .b_i  (sliceB),
    .lt_o (sliceLt),
    .eq_o (sliceEq),
    .gt_o (sliceGt)
  );

`ifdef COMPARATOR_EARLY_EXIT_EN
  assign runDone = (idx_q == '0) || !sliceEq;
`else
  assign runDone = (idx_q == '0);
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= IDLE;
      opA_q    <= '0;
      opB_q    <= '0;
      idx_q    <= '0;
      slices_q <= '0;
      res_q    <= RES_NONE;
    end else begin
      state_q  <= state_d;
      opA_q    <= opA_d;
      opB_q    <= opB_d;
      idx_q    <= idx_d;
      slices_q <= slices_d;
      res_q    <= res_d;
    end
  end

  // res_q doubles as the sticky decision during RUN and the reported result in HOLD.
  always_comb begin
    state_d  = state_q;
    opA_d    = opA_q;
    opB_d    = opB_q;
    idx_d    = idx_q;
    slices_d = slices_q;
    res_d    = res_q;
    unique case (state_q)
      IDLE: begin
        if (IN_VALID) begin
          opA_d    = A;
          opB_d    = B;
          idx_d    = IDX_MAX;
          slices_d = '0;
          res_d    = RES_NONE;
          state_d  = RUN;
        end
      end
      RUN: begin
        slices_d = slices_q + SLICES_W'(1);
        if (res_q == RES_NONE && !sliceEq) begin
          res_d = {sliceLt, 1'b0, sliceGt};
        end
        if (runDone) begin
          state_d = HOLD;
          if (res_d == RES_NONE) begin
            res_d = RES_EQ;
          end
        end else begin
          idx_d = idx_q - IDX_W'(1);
        end
      end
      HOLD: begin
        if (OUT_READY) begin
          res_d   = RES_NONE;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    IN_READY  = (state_q == IDLE);
    OUT_VALID = (state_q == HOLD);
    {LT_OUT, EQ_OUT, GT_OUT} = (state_q == HOLD) ? res_q : RES_NONE;
    SLICES    = slices_q;
  end

endmodule

// File: tb/tb_comparator_seq_ctrl.sv
// Scoreboard bench for comparator_seq_ctrl: expectations are queued at operand issue
// and popped when the result appears.
module tb_comparator_seq_ctrl;

   localparam int WIDTH = 32;
   localparam int NSL   = WIDTH / 4;

   logic             CLK = 1'b0;
   logic             RST;
   logic             IN_VALID;
   logic             IN_READY;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic             OUT_VALID;
   logic             OUT_READY;
   logic             LT_OUT;
   logic             EQ_OUT;
   logic             GT_OUT;
   logic [3:0]       SLICES;

   typedef struct {
      logic [2:0] res;
      int         slices;
   } exp_t;

   exp_t expQ[$];
   int   vectors     = 0;
   int   miscompares = 0;

   always #5 CLK = ~CLK;

   comparator_seq_ctrl #(.WIDTH(WIDTH)) dut (
      .CLK       (CLK),
      .RST       (RST),
      .IN_VALID  (IN_VALID),
      .IN_READY  (IN_READY),
      .A         (A),
      .B         (B),
      .OUT_VALID (OUT_VALID),
      .OUT_READY (OUT_READY),
      .LT_OUT    (LT_OUT),
      .EQ_OUT    (EQ_OUT),
      .GT_OUT    (GT_OUT),
      .SLICES    (SLICES)
   );

   // Advance one clock and settle away from the active edge.
   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   // Reference: result from a full-width compare; slice count from the first differing nibble.
   function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
      exp_t e;
      int   firstDiff;
      e.res = (a < b) ? 3'b100 : ((a == b) ? 3'b010 : 3'b001);
      firstDiff = NSL;
      for (int i = 0; i < NSL; i++) begin
         if (firstDiff == NSL && ((a >> (4 * (NSL - 1 - i))) & 32'hF) != ((b >> (4 * (NSL - 1 - i))) & 32'hF))
            firstDiff = i + 1;
      end
`ifdef COMPARATOR_EARLY_EXIT_EN
      e.slices = firstDiff;
`else
      e.slices = NSL;
`endif
      return e;
   endfunction

   // Hands one operand pair over, queues its expectation, then counts cycles to OUT_VALID.
   task automatic issue(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, output int lat);
      int waitCycles = 0;
      while (!IN_READY && waitCycles < 50) begin
         tick();
         waitCycles++;
      end
      IN_VALID = 1'b1;
      A = a;
      B = b;
      expQ.push_back(model(a, b));
      tick();
      IN_VALID = 1'b0;
      A = $urandom;
      B = $urandom;
      lat = 0;
      while (!OUT_VALID && lat < 40) begin
         tick();
         lat++;
      end
   endtask

   task automatic test_reset();
      RST = 1'b1;
      IN_VALID = 1'b0;
      OUT_READY = 1'b0;
      A = '0;
      B = '0;
      repeat (3) tick();
      vectors++;
      if (IN_READY !== 1'b1) begin
         miscompares++;
         $display("[TB] FAIL reset IN_READY: got %b, want 1", IN_READY);
      end
      vectors++;
      if (OUT_VALID !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL reset OUT_VALID: got %b, want 0", OUT_VALID);
      end
      vectors++;
      if ({LT_OUT, EQ_OUT, GT_OUT} !== 3'b000) begin
         miscompares++;
         $display("[TB] FAIL reset LT/EQ/GT: got %b, want 000", {LT_OUT, EQ_OUT, GT_OUT});
      end
      vectors++;
      if (SLICES !== 4'd0) begin
         miscompares++;
         $display("[TB] FAIL reset SLICES: got %0d, want 0", SLICES);
      end
      RST = 1'b0;
      tick();
   endtask

   task automatic test_compare_pairs();
      logic [WIDTH-1:0] pa[$];
      logic [WIDTH-1:0] pb[$];
      logic [WIDTH-1:0] r;
      exp_t e;
      int   lat;
      pa = '{32'hDEADBEEF, 32'h80000000, 32'h12345670, 32'h00000000, 32'hFFFFFFFF};
      pb = '{32'hDEADBEEF, 32'h7FFFFFFF, 32'h12345671, 32'hFFFFFFFF, 32'hFFFFFFFE};
      for (int k = 0; k < 6; k++) begin
         r = $urandom;
         pa.push_back(r);
         case (k % 3)
            0:       pb.push_back(r);
            1:       pb.push_back(r ^ (32'h1 << $urandom_range(0, 31)));
            default: pb.push_back($urandom);
         endcase
      end
      OUT_READY = 1'b1;
      for (int p = 0; p < pa.size(); p++) begin
         issue(pa[p], pb[p], lat);
         e = expQ.pop_front();
         vectors++;
         if (lat !== e.slices) begin
            miscompares++;
            $display("[TB] FAIL latency pair%0d: got %0d, want %0d", p, lat, e.slices);
         end
         vectors++;
         if ({LT_OUT, EQ_OUT, GT_OUT} !== e.res) begin
            miscompares++;
            $display("[TB] FAIL result pair%0d A=%h B=%h: got %b, want %b", p, pa[p], pb[p], {LT_OUT, EQ_OUT, GT_OUT}, e.res);
         end
         vectors++;
         if (SLICES !== 4'(e.slices)) begin
            miscompares++;
            $display("[TB] FAIL slices pair%0d: got %0d, want %0d", p, SLICES, e.slices);
         end
         tick();
         vectors++;
         if ({IN_READY, OUT_VALID, LT_OUT, EQ_OUT, GT_OUT} !== 5'b10000) begin
            miscompares++;
            $display("[TB] FAIL release pair%0d {IN_READY,OUT_VALID,LT,EQ,GT}: got %b, want 10000", p, {IN_READY, OUT_VALID, LT_OUT, EQ_OUT, GT_OUT});
         end
      end
   endtask

   task automatic test_backpressure();
      exp_t e;
      int   lat;
      OUT_READY = 1'b0;
      issue(32'h0000_1000, 32'h0000_0FFF, lat);
      e = expQ.pop_front();
      vectors++;
      if ({LT_OUT, EQ_OUT, GT_OUT} !== e.res) begin
         miscompares++;
         $display("[TB] FAIL backpressure result: got %b, want %b", {LT_OUT, EQ_OUT, GT_OUT}, e.res);
      end
      IN_VALID = 1'b1;
      A = 32'h0000_0005;
      B = 32'h0000_0009;
      for (int c = 0; c < 5; c++) begin
         tick();
         vectors++;
         if ({OUT_VALID, IN_READY, LT_OUT, EQ_OUT, GT_OUT} !== {2'b10, e.res} || SLICES !== 4'(e.slices)) begin
            miscompares++;
            $display("[TB] FAIL hold cycle%0d {OUT_VALID,IN_READY,LT,EQ,GT}/SLICES: got %b/%0d, want %b/%0d",
                     c, {OUT_VALID, IN_READY, LT_OUT, EQ_OUT, GT_OUT}, SLICES, {2'b10, e.res}, e.slices);
         end
      end
      OUT_READY = 1'b1;
      tick();
      vectors++;
      if ({IN_READY, OUT_VALID} !== 2'b10) begin
         miscompares++;
         $display("[TB] FAIL after handshake {IN_READY,OUT_VALID}: got %b, want 10", {IN_READY, OUT_VALID});
      end
      issue(32'h0000_0005, 32'h0000_0009, lat);
      e = expQ.pop_front();
      vectors++;
      if ({LT_OUT, EQ_OUT, GT_OUT} !== e.res || lat !== e.slices) begin
         miscompares++;
         $display("[TB] FAIL held-operand result/latency: got %b/%0d, want %b/%0d", {LT_OUT, EQ_OUT, GT_OUT}, lat, e.res, e.slices);
      end
      tick();
   endtask

   task automatic test_reset_mid_run();
      exp_t e;
      int   lat;
      OUT_READY = 1'b1;
      IN_VALID = 1'b1;
      A = 32'hCAFEF00D;
      B = 32'hCAFEF00D;
      tick();
      IN_VALID = 1'b0;
      repeat (3) tick();
      vectors++;
      if (SLICES !== 4'd3 || OUT_VALID !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL mid-run SLICES/OUT_VALID: got %0d/%b, want 3/0", SLICES, OUT_VALID);
      end
      RST = 1'b1;
      tick();
      RST = 1'b0;
      vectors++;
      if ({IN_READY, OUT_VALID, LT_OUT, EQ_OUT, GT_OUT} !== 5'b10000 || SLICES !== 4'd0) begin
         miscompares++;
         $display("[TB] FAIL post-reset {IN_READY,OUT_VALID,LT,EQ,GT}/SLICES: got %b/%0d, want 10000/0",
                  {IN_READY, OUT_VALID, LT_OUT, EQ_OUT, GT_OUT}, SLICES);
      end
      issue(32'h0F00_0000, 32'h0E00_0000, lat);
      e = expQ.pop_front();
      vectors++;
      if ({LT_OUT, EQ_OUT, GT_OUT} !== e.res || lat !== e.slices || SLICES !== 4'(e.slices)) begin
         miscompares++;
         $display("[TB] FAIL post-reset compare result/latency/slices: got %b/%0d/%0d, want %b/%0d/%0d",
                  {LT_OUT, EQ_OUT, GT_OUT}, lat, SLICES, e.res, e.slices, e.slices);
      end
      tick();
   endtask

   initial begin
      test_reset();
      test_compare_pairs();
      test_backpressure();
      test_reset_mid_run();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
